// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings and default constants
// for the IF/MA single-port memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MA = 1'b1
    } owner_e;

    localparam int DEF_ADDR_W     = 24;
    localparam int DEF_DATA_W     = 24;
    localparam int DEF_LATENCY    = 2;
    localparam int DEF_STARVE_MAX = 4;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/mem_arb_counter.sv
// mem_arb_counter: loadable down-counter with zero flag; sat_i
// selects whether it holds at zero instead of wrapping.
module mem_arb_counter
    import mem_arbiter_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             sat_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !(sat_i && cnt_q == '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates IF fetches and MA loads/stores onto a
// single-port memory with fixed read latency.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ma_req,
    input  logic              ma_we,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic              ma_done,
    output logic [DATA_W-1:0] ma_rdata,
    output logic              stall_if,
    output logic              stall_ma,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        st_q, st_d;
    owner_e            own_q, own_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;
    logic              grant_if, grant_ma;
    logic              wait_zero, starve_zero;

    // Starvation is tracked as remaining MA credit: zero forces IF.
    mem_arb_counter #(
        .RST_VAL(CNT_W'(STARVE_MAX))
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .load_i    (grant_if || (st_q == ST_IDLE && !if_req)),
        .load_val_i(CNT_W'(STARVE_MAX)),
        .dec_i     (grant_ma && if_req),
        .sat_i     (1'b1),
        .zero_o    (starve_zero)
    );

    mem_arb_counter u_wait (
        .clk       (clk),
        .rst       (rst),
        .load_i    (st_q == ST_ISSUE),
        .load_val_i(CNT_W'(LATENCY - 1)),
        .dec_i     (st_q == ST_WAIT),
        .sat_i     (1'b0),
        .zero_o    (wait_zero)
    );

    always_comb begin
        st_d       = st_q;
        own_d      = own_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ma_rdata_d = ma_rdata_q;
        grant_if   = 1'b0;
        grant_ma   = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                grant_ma = ma_req && !(if_req && starve_zero);
                grant_if = if_req && !grant_ma;
                if (grant_ma) begin
                    own_d   = OWN_MA;
                    we_d    = ma_we;
                    addr_d  = ma_addr;
                    wdata_d = ma_wdata;
                    st_d    = ST_ISSUE;
                end else if (grant_if) begin
                    own_d   = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    st_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: st_d = ST_WAIT;
            ST_WAIT: begin
                if (wait_zero) begin
                    st_d = ST_DONE;
                    if (own_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        ma_rdata_d = mem_rdata;
                    end
                end
            end
            ST_DONE: st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            own_q      <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ma_rdata_q <= '0;
        end else begin
            st_q       <= st_d;
            own_q      <= own_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ma_rdata_q <= ma_rdata_d;
        end
    end

    assign mem_req   = (st_q == ST_ISSUE);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;

    assign if_done  = (st_q == ST_DONE) && (own_q == OWN_IF);
    assign ma_done  = (st_q == ST_DONE) && (own_q == OWN_MA);
    assign if_rdata = if_rdata_q;
    assign ma_rdata = ma_rdata_q;
    assign stall_if = if_req && !if_done;
    assign stall_ma = ma_req && !ma_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters, a memory model and a
// scoreboard/monitor checking grants, timing and returned data.
module tb_mem_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;
    localparam int XLAT [2] = '{1, 15};
    localparam logic [23:0] X_GOOD = 24'hC0FFEE;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_done, ma_req, ma_we, ma_done;
    logic [23:0] if_addr, if_rdata, ma_addr, ma_wdata, ma_rdata;
    logic        stall_if, stall_ma, mem_req, mem_we;
    logic [23:0] mem_addr, mem_wdata, mem_rdata;

    logic        x_ma_req [2];
    logic [23:0] x_ma_addr [2];
    logic        x_if_done [2], x_ma_done [2];
    logic        x_stall_if [2], x_stall_ma [2];
    logic        x_mem_req [2], x_mem_we [2];
    logic [23:0] x_if_rdata [2], x_ma_rdata [2];
    logic [23:0] x_mem_addr [2], x_mem_wdata [2], x_mem_rdata [2];
    int          x_rdcyc [2] = '{-100, -100};

    int cyc = 0;
    int nvec = 0;
    int nerr = 0;

    logic [23:0] if_q [$];
    logic [23:0] ma_q [$];
    bit          grant_log [$];
    logic [23:0] ref_mem [logic [23:0]];
    logic [23:0] dev_mem [logic [23:0]];
    logic [23:0] t_last_ma = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_rdata(if_rdata),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr),
        .ma_wdata(ma_wdata), .ma_done(ma_done), .ma_rdata(ma_rdata),
        .stall_if(stall_if), .stall_ma(stall_ma),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    for (genvar g = 0; g < 2; g++) begin : gx
        mem_arbiter #(.LATENCY(XLAT[g])) u_x (
            .clk(clk), .rst(rst),
            .if_req(1'b0), .if_addr(24'h0),
            .if_done(x_if_done[g]), .if_rdata(x_if_rdata[g]),
            .ma_req(x_ma_req[g]), .ma_we(1'b0),
            .ma_addr(x_ma_addr[g]), .ma_wdata(24'h0),
            .ma_done(x_ma_done[g]), .ma_rdata(x_ma_rdata[g]),
            .stall_if(x_stall_if[g]), .stall_ma(x_stall_ma[g]),
            .mem_req(x_mem_req[g]), .mem_we(x_mem_we[g]),
            .mem_addr(x_mem_addr[g]), .mem_wdata(x_mem_wdata[g]),
            .mem_rdata(x_mem_rdata[g])
        );
    end

    function automatic logic [23:0] init_val(input logic [23:0] a);
        if (a == 24'h10) return 24'hABCDEF;
        return (a * 24'd40503) ^ 24'h5A5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    // Memory macro: reads return data only in cycle t+LAT.
    bit          rd_pend = 0;
    int          rd_cyc;
    logic [23:0] rd_val;
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            rd_pend = 0;
        end else if (mem_req) begin
            if (mem_we) begin
                dev_mem[mem_addr] = mem_wdata;
            end else begin
                rd_pend = 1;
                rd_cyc  = cyc + LAT;
                rd_val  = dev_mem.exists(mem_addr) ?
                          dev_mem[mem_addr] : init_val(mem_addr);
            end
        end
        if (rd_pend && cyc == rd_cyc) begin
            mem_rdata = rd_val;
            rd_pend   = 0;
        end else begin
            mem_rdata = 24'($urandom);
        end
        for (int k = 0; k < 2; k++) begin
            if (x_mem_req[k]) x_rdcyc[k] = cyc + XLAT[k];
            x_mem_rdata[k] = (cyc == x_rdcyc[k]) ?
                             (X_GOOD ^ 24'(k)) : 24'($urandom);
        end
    end

    // Monitor: abstract arbiter model (free/busy, priority, starvation).
    bit          m_idle = 1, m_pend = 0, e_own, e_we, ma_wins;
    int          m_starve = 0, e_issue, e_done;
    logic [23:0] e_addr, e_wdata, m_last_if = '0, m_last_ma = '0;
    logic [23:0] ex;
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_mem_req", 32'(mem_req), 0);
            chk("rst_done", 32'({if_done, ma_done}), 0);
            chk("rst_rdata", 32'(if_rdata | ma_rdata), 0);
            m_idle = 1; m_pend = 0; m_starve = 0;
            m_last_if = '0; m_last_ma = '0;
        end else begin
            chk("stall_if", 32'(stall_if), 32'(if_req && !if_done));
            chk("stall_ma", 32'(stall_ma), 32'(ma_req && !ma_done));
            chk("done_excl", 32'(if_done && ma_done), 0);
            if (m_idle && !if_req) m_starve = 0;
            if (m_idle && (if_req || ma_req)) begin
                ma_wins = ma_req && !(if_req && m_starve == SMAX);
                if (ma_wins) begin
                    e_own = 1; e_we = ma_we;
                    e_addr = ma_addr; e_wdata = ma_wdata;
                    if (if_req && m_starve < SMAX) m_starve++;
                end else begin
                    e_own = 0; e_we = 0;
                    e_addr = if_addr; e_wdata = '0;
                    m_starve = 0;
                end
                grant_log.push_back(e_own);
                m_idle = 0; m_pend = 1;
                e_issue = cyc + 1;
                e_done  = cyc + LAT + 2;
            end
            chk("mem_req", 32'(mem_req), 32'(m_pend && cyc == e_issue));
            if (mem_req) begin
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                if (e_own) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            end else begin
                chk("idle_bus", 32'(mem_we) | 32'(mem_addr) | 32'(mem_wdata), 0);
            end
            chk("if_done", 32'(if_done), 32'(m_pend && cyc == e_done && !e_own));
            chk("ma_done", 32'(ma_done), 32'(m_pend && cyc == e_done && e_own));
            if (m_pend && cyc == e_done) begin
                if (!e_own) begin
                    chk("if_sb_depth", 32'(if_q.size() > 0), 1);
                    if (if_q.size() > 0) begin
                        ex = if_q.pop_front();
                        chk("if_rdata", 32'(if_rdata), 32'(ex));
                        m_last_if = ex;
                    end
                end else begin
                    chk("ma_sb_depth", 32'(ma_q.size() > 0), 1);
                    if (ma_q.size() > 0) begin
                        ex = ma_q.pop_front();
                        chk("ma_rdata", 32'(ma_rdata), 32'(ex));
                        m_last_ma = ex;
                    end
                end
                m_pend = 0; m_idle = 1;
            end else begin
                chk("if_rdata_hold", 32'(if_rdata), 32'(m_last_if));
                chk("ma_rdata_hold", 32'(ma_rdata), 32'(m_last_ma));
            end
        end
    end

    always @(posedge clk) begin
        if (cyc > 50000) begin
            $display("FAIL watchdog: cycle %0d exceeds 50000", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic if_txn(input logic [23:0] a, output int s, output int d);
        if_addr = a; if_req = 1; s = cyc; d = -1;
        if_q.push_back(init_val(a));
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (if_done) begin d = cyc; break; end
        end
        chk("if_done_seen", 32'(d >= 0), 1);
        @(posedge clk); #2;
        if_req = 0;
    endtask

    task automatic ma_txn(input logic we, input logic [23:0] a,
                          input logic [23:0] wd, output int s, output int d);
        logic [23:0] e;
        if (we) begin
            ref_mem[a] = wd;
            e = t_last_ma;
        end else begin
            e = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
            t_last_ma = e;
        end
        ma_q.push_back(e);
        ma_we = we; ma_addr = a; ma_wdata = wd; ma_req = 1;
        s = cyc; d = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (ma_done) begin d = cyc; break; end
        end
        chk("ma_done_seen", 32'(d >= 0), 1);
        @(posedge clk); #2;
        ma_req = 0;
    endtask

    task automatic rand_if(input int n);
        int s, d, k;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 3);
            repeat (k) begin @(posedge clk); #2; end
            if_txn(24'($urandom_range(0, 255)), s, d);
        end
    endtask

    task automatic rand_ma(input int n);
        int s, d, k;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 3);
            repeat (k) begin @(posedge clk); #2; end
            ma_txn(1'($urandom_range(0, 1)),
                   24'h1000 + 24'($urandom_range(0, 15)),
                   24'($urandom), s, d);
        end
    endtask

    task automatic x_txn(input int k);
        int s, d, np;
        np = 0; d = -1;
        x_ma_addr[k] = 24'h300 + 24'(k);
        x_ma_req[k] = 1; s = cyc;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (x_mem_req[k]) begin
                np++;
                chk("x_mem_addr", 32'(x_mem_addr[k]), 32'(x_ma_addr[k]));
                chk("x_mem_we", 32'(x_mem_we[k]), 0);
            end
            chk("x_if_done", 32'(x_if_done[k]), 0);
            if (x_ma_done[k]) begin
                d = cyc;
                chk("x_ma_rdata", 32'(x_ma_rdata[k]), 32'(X_GOOD ^ 24'(k)));
                break;
            end
        end
        chk("x_mem_req_cnt", 32'(np), 1);
        chk("x_done_cyc", 32'(d), 32'(s + XLAT[k] + 2));
        @(posedge clk); #2;
        x_ma_req[k] = 0;
    endtask

    initial begin
        int s1, d1, s2, d2, r;
        rst = 1;
        if_req = 0; if_addr = '0;
        ma_req = 0; ma_we = 0; ma_addr = '0; ma_wdata = '0;
        x_ma_req = '{0, 0};
        x_ma_addr = '{24'h0, 24'h0};
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", 32'({if_done, ma_done, mem_req, stall_if, stall_ma}), 0);
        rst = 0;
        @(posedge clk); #2;

        if_txn(24'h000010, s1, d1);
        chk("t1_if_done_cyc", 32'(d1), 32'(s1 + 4));

        ma_txn(1'b1, 24'h001234, 24'h55AA55, s1, d1);
        chk("t2_ma_done_cyc", 32'(d1), 32'(s1 + 4));

        fork
            ma_txn(1'b0, 24'h000020, 24'h0, s1, d1);
            if_txn(24'h000024, s2, d2);
        join
        chk("t3_ma_first", 32'(d1), 32'(s1 + 4));
        chk("t3_if_second", 32'(d2), 32'(s2 + 9));

        grant_log.delete();
        fork
            if_txn(24'h000040, s2, d2);
            begin
                for (int i = 0; i < 6; i++)
                    ma_txn(1'b0, 24'h1000 + 24'(i), 24'h0, s1, d1);
            end
        join
        chk("t4_grants", 32'(grant_log.size()), 7);
        for (int i = 0; i < 7 && i < grant_log.size(); i++)
            chk($sformatf("t4_grant%0d", i), 32'(grant_log[i]),
                32'(i != 4));

        fork
            rand_if(40);
            rand_ma(60);
        join

        fork
            ma_txn(1'b0, 24'h001003, 24'h0, s1, d1);
            begin
                int n;
                for (n = 0; n < 20; n++) begin
                    @(negedge clk);
                    if (mem_req) break;
                end
                chk("t5_issue_seen", 32'(n < 20), 1);
                @(posedge clk); #2;
                rst = 1;
                @(posedge clk); #2;
                rst = 0;
                r = cyc;
            end
        join
        chk("t5_fresh_done", 32'(d1), 32'(r + 4));

        x_txn(0);
        x_txn(1);

        repeat (3) @(posedge clk);
        chk("if_sb_empty", 32'(if_q.size()), 0);
        chk("ma_sb_empty", 32'(ma_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
